// File: rtl/deserializacion_s2p_pkg.sv
// Shared lane constants, FSM encoding and output payload for the S2P stage.
package deserializacion_s2p_pkg;

  localparam int unsigned DATA_W    = 8;
  localparam logic [DATA_W-1:0] COM = 8'hBC;
  localparam int unsigned N_COM_DEF = 4;
  localparam int unsigned BIT_CNT_W = 3;
  localparam int unsigned COM_CNT_W = 4;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              valid;
    logic              active;
    logic              strobe;
  } deser_out_t;

endpackage

// File: rtl/deser_shift_reg.sv
// Serial history register; cand_c is the symbol that ends with the current bit.
module deser_shift_reg
  import deserializacion_s2p_pkg::*;
(
  input  logic              clk_8f,
  input  logic              reset_L,
  input  logic              data_in,
  output logic [DATA_W-1:0] cand_c
);

  // Only the previous DATA_W-1 bits are kept: the oldest bit of the full
  // register would fall out of every candidate before anyone could read it.
  logic [DATA_W-2:0] hist_q;

  assign cand_c = {hist_q, data_in};

  // Shift in one bit per clock, MSB of the symbol arriving first.
  always_ff @(posedge clk_8f or negedge reset_L) begin
    if (!reset_L) begin
      hist_q <= '0;
    end else begin
      hist_q <= cand_c[DATA_W-2:0];
    end
  end

endmodule

// File: rtl/deserializacion_s2p.sv
// Serial-to-parallel lane: COM-based byte alignment, then one byte per DATA_W bits.
module deserializacion_s2p
  import deserializacion_s2p_pkg::*;
#(
  parameter int unsigned N_COM = N_COM_DEF
) (
  input  logic              clk_8f,
  input  logic              reset_L,
  input  logic              data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              active_out,
  output logic              byte_strobe
);

  localparam logic [BIT_CNT_W-1:0] LAST_BIT   = BIT_CNT_W'(DATA_W - 1);
  localparam logic [COM_CNT_W-1:0] COM_TARGET = COM_CNT_W'(N_COM);
  localparam logic [COM_CNT_W-1:0] COM_ONE    = COM_CNT_W'(1);

  state_t                 state_q, state_d;
  logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [COM_CNT_W-1:0]   com_cnt_q, com_cnt_d;
  deser_out_t             out_q, out_d;
  logic [DATA_W-1:0]      cand_c;
  logic                   is_com_c;
  logic                   boundary_c;

  deser_shift_reg u_shift (
    .clk_8f  (clk_8f),
    .reset_L (reset_L),
    .data_in (data_in),
    .cand_c  (cand_c)
  );

  assign is_com_c   = (cand_c == COM);
  assign boundary_c = (bit_cnt_q == LAST_BIT);

  // Next-state, counter and output-register decisions, all taken from cand.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q + BIT_CNT_W'(1);
    com_cnt_d    = com_cnt_q;
    out_d        = out_q;
    out_d.strobe = 1'b0;

    case (state_q)
      SEARCH: begin
        bit_cnt_d = '0;
        if (is_com_c) begin
          com_cnt_d = COM_ONE;
          state_d   = (COM_TARGET == COM_ONE) ? ACTIVE : ALIGN;
        end
      end
      ALIGN: begin
        if (boundary_c) begin
          if (is_com_c) begin
            com_cnt_d = com_cnt_q + COM_ONE;
            if (com_cnt_q + COM_ONE == COM_TARGET) begin
              state_d = ACTIVE;
            end
          end else begin
            // Restart the sliding search on the very next bit, no slip.
            com_cnt_d = '0;
            state_d   = SEARCH;
          end
        end
      end
      ACTIVE: begin
        if (boundary_c) begin
          out_d.strobe = 1'b1;
          if (is_com_c) begin
            out_d.valid = 1'b0;
          end else begin
            out_d.data  = cand_c;
            out_d.valid = 1'b1;
          end
        end
      end
      default: begin
        state_d = SEARCH;
      end
    endcase

    out_d.active = (state_d == ACTIVE);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk_8f or negedge reset_L) begin
    if (!reset_L) begin
      state_q   <= SEARCH;
      bit_cnt_q <= '0;
      com_cnt_q <= '0;
      out_q     <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      com_cnt_q <= com_cnt_d;
      out_q     <= out_d;
    end
  end

  assign data_out    = out_q.data;
  assign valid_out   = out_q.valid;
  assign active_out  = out_q.active;
  assign byte_strobe = out_q.strobe;

endmodule

// File: tb/tb_deserializacion_s2p.sv
// Directed plus randomized bench for the S2P lane against a cycle-time reference model.
module tb_deserializacion_s2p;

  localparam int  NC  = 4;
  localparam int  SYM = 8;
  localparam int  CM  = 8'hBC;

  logic       clk_8f = 1'b0;
  logic       reset_L = 1'b0;
  logic       data_in = 1'b0;
  logic [7:0] data_out;
  logic       valid_out;
  logic       active_out;
  logic       byte_strobe;

  int checks = 0;
  int errors = 0;

  // Reference model: absolute cycle numbers of expected boundaries.
  int   t;
  int   win;
  int   next_b;
  int   run;
  bit   locked;
  int   m_data;
  bit   m_valid;
  bit   m_strobe;

  deserializacion_s2p dut (
    .clk_8f      (clk_8f),
    .reset_L     (reset_L),
    .data_in     (data_in),
    .data_out    (data_out),
    .valid_out   (valid_out),
    .active_out  (active_out),
    .byte_strobe (byte_strobe)
  );

  always #5 clk_8f = ~clk_8f;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    t = 0; win = 0; next_b = -1; run = 0; locked = 0;
    m_data = 0; m_valid = 0; m_strobe = 0;
  endtask

  task automatic model_step(input bit b);
    t++;
    win = ((win << 1) | int'(b)) & 8'hFF;
    m_strobe = 0;
    if (next_b < 0) begin
      if (win == CM) begin
        run = 1;
        next_b = t + SYM;
        if (run == NC) locked = 1;
      end
    end else if (t == next_b) begin
      next_b += SYM;
      if (locked) begin
        m_strobe = 1;
        if (win != CM) begin
          m_data = win;
          m_valid = 1;
        end else begin
          m_valid = 0;
        end
      end else if (win == CM) begin
        run++;
        if (run == NC) locked = 1;
      end else begin
        run = 0;
        next_b = -1;
      end
    end
  endtask

  task automatic check_all();
    chk("data_out", 32'(data_out), 32'(m_data));
    chk("valid_out", 32'(valid_out), 32'(m_valid));
    chk("active_out", 32'(active_out), 32'(locked));
    chk("byte_strobe", 32'(byte_strobe), 32'(m_strobe));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_data"}, 32'(data_out), 32'd0);
    chk({tag, "_valid"}, 32'(valid_out), 32'd0);
    chk({tag, "_active"}, 32'(active_out), 32'd0);
    chk({tag, "_strobe"}, 32'(byte_strobe), 32'd0);
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic bit_cycle(input bit b);
    data_in = b;
    @(posedge clk_8f);
    model_step(b);
    @(negedge clk_8f);
    check_all();
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) bit_cycle(v[i]);
  endtask

  task automatic send_coms(input int n);
    for (int i = 0; i < n; i++) send_byte(8'hBC);
  endtask

  // Asynchronous reset from a negedge: outputs must clear before any clock edge.
  task automatic pulse_reset(input string tag);
    #2 reset_L = 1'b0;
    #1 check_zero({tag, "_async"});
    model_reset();
    @(negedge clk_8f);
    for (int i = 0; i < 3; i++) begin
      data_in = ~data_in;
      @(negedge clk_8f);
      check_zero({tag, "_hold"});
    end
    reset_L = 1'b1;
  endtask

  initial begin
    logic [7:0] rb;
    model_reset();

    // 1: reset held with toggling data, outputs zero; no strobe before lock.
    #1 check_zero("rst_init");
    @(negedge clk_8f);
    for (int i = 0; i < 3; i++) begin
      data_in = ~data_in;
      @(negedge clk_8f);
      check_zero("rst_hold");
    end
    reset_L = 1'b1;

    // 2: lock after four COMs, then two data bytes.
    send_coms(3);
    send_byte(8'hBC);
    chk("s2_active", 32'(active_out), 32'd1);
    send_byte(8'hA5);
    chk("s2_a5", 32'(data_out), 32'hA5);
    chk("s2_a5_valid", 32'(valid_out), 32'd1);
    send_byte(8'h3C);
    chk("s2_3c", 32'(data_out), 32'h3C);

    // 3: COMs in ACTIVE drop valid but hold the data byte.
    send_byte(8'hA5);
    send_byte(8'hBC);
    chk("s3_bc_valid", 32'(valid_out), 32'd0);
    chk("s3_bc_hold", 32'(data_out), 32'hA5);
    send_byte(8'hBC);
    send_byte(8'h7E);
    chk("s3_7e", 32'(data_out), 32'h7E);
    chk("s3_7e_valid", 32'(valid_out), 32'd1);

    // 4: lock with a three-bit offset.
    pulse_reset("s4");
    bit_cycle(1'b1); bit_cycle(1'b0); bit_cycle(1'b1);
    send_coms(NC);
    send_byte(8'h11);
    chk("s4_11", 32'(data_out), 32'h11);
    chk("s4_active", 32'(active_out), 32'd1);

    // 5: short COM run broken by data, then a full run.
    pulse_reset("s5");
    send_coms(3);
    send_byte(8'h11);
    chk("s5_no_lock", 32'(active_out), 32'd0);
    chk("s5_no_valid", 32'(valid_out), 32'd0);
    send_coms(NC);
    send_byte(8'h22);
    chk("s5_22", 32'(data_out), 32'h22);

    // 6: reset mid-byte while ACTIVE, then relock.
    bit_cycle(1'b1); bit_cycle(1'b1); bit_cycle(1'b0);
    pulse_reset("s6");
    send_coms(NC);
    send_byte(8'h5A);
    chk("s6_5a", 32'(data_out), 32'h5A);
    chk("s6_active", 32'(active_out), 32'd1);

    // Randomized traffic: offsets, COM runs of random length, mixed bytes, resets.
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 5) == 0) begin
        for (int j = $urandom_range(0, 6); j > 0; j--) bit_cycle(1'($urandom_range(0, 1)));
        pulse_reset("rnd");
      end
      for (int j = $urandom_range(0, 7); j > 0; j--) bit_cycle(1'($urandom_range(0, 1)));
      send_coms($urandom_range(1, 5));
      for (int j = $urandom_range(1, 6); j > 0; j--) begin
        rb = ($urandom_range(0, 9) < 3) ? 8'hBC : 8'($urandom);
        send_byte(rb);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
